// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register
// and the halt/drain sequencer that stops fetch once the HALT word reaches ID.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W  = 10,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   stallF,
  input  logic                   stallD,
  input  logic                   flushIFID,
  input  logic [1:0]             pc_src,
  input  logic [31:0]            branch_target_ID,
  input  logic [31:0]            jump_target_ID,
  input  logic [31:0]            reg_target_ID,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic [31:0]            pc_IF,
  output logic [31:0]            instr_ID,
  output logic [31:0]            pc_plus4_ID,
  output logic                   valid_ID,
  output logic                   halted
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_HOLD = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    case (pc_src)
      2'b01:   next_pc = branch_target_ID;
      2'b10:   next_pc = jump_target_ID;
      2'b11:   next_pc = reg_target_ID;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    if (enable) begin
      if (!stallF && state_q == RUN) begin
        pc_d = next_pc;
      end

      // stallD outranks flushIFID: a held ID instruction is never squashed.
      if (!stallD) begin
        if (flushIFID) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
          pc4_d   = pc_plus4;
        end else if (state_q != RUN) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
        end else begin
          instr_d = imem_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end

      if (state_q == HALTED) begin
        halted_d = 1'b1;
      end

      case (state_q)
        RUN: begin
          if (!stallD && !flushIFID && imem_data == HALT_INSTR) begin
            state_d = HALT_HOLD;
          end
        end
        HALT_HOLD: begin
          if (!stallD) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = HALTED;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = HALTED;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc_IF       = pc_q;
  assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign instr_ID    = instr_q;
  assign pc_plus4_ID = pc4_q;
  assign valid_ID    = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: straight-line fetch, stalls, redirects,
// halt/drain timing, enable freeze and asynchronous reset.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stallF;
  logic        stallD;
  logic        flushIFID;
  logic [1:0]  pc_src;
  logic [31:0] branch_target_ID;
  logic [31:0] jump_target_ID;
  logic [31:0] reg_target_ID;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_IF;
  logic [31:0] instr_ID;
  logic [31:0] pc_plus4_ID;
  logic        valid_ID;
  logic        halted;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .stallF           (stallF),
    .stallD           (stallD),
    .flushIFID        (flushIFID),
    .pc_src           (pc_src),
    .branch_target_ID (branch_target_ID),
    .jump_target_ID   (jump_target_ID),
    .reg_target_ID    (reg_target_ID),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .pc_IF            (pc_IF),
    .instr_ID         (instr_ID),
    .pc_plus4_ID      (pc_plus4_ID),
    .valid_ID         (valid_ID),
    .halted           (halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge and sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable    = 1'b1;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushIFID = 1'b0;
    pc_src    = 2'b00;
    branch_target_ID = 32'd0;
    jump_target_ID   = 32'd0;
    reg_target_ID    = 32'd0;
    imem_data = 32'd0;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
    chk({tag, "_pc"},    pc_IF, pc);
    chk({tag, "_instr"}, instr_ID, ins);
    chk({tag, "_pc4"},   pc_plus4_ID, p4);
    chk({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, v});
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset_imem_addr", {22'd0, imem_addr}, 32'h0);
    chk("reset_halted", {31'd0, halted}, 32'h0);
    rst_n = 1'b1;

    // straight-line fetch
    imem_data = 32'h2008_0005;
    step();
    chk_ifid("seq0", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    imem_data = 32'h1111_1111;
    step();
    chk_ifid("seq1", 32'h8, 32'h1111_1111, 32'h8, 1'b1);
    chk("seq1_imem_addr", {22'd0, imem_addr}, 32'h2);

    // stall both stages for two cycles at PC=8
    stallF = 1'b1; stallD = 1'b1; imem_data = 32'h2222_2222;
    step();
    chk_ifid("stall0", 32'h8, 32'h1111_1111, 32'h8, 1'b1);
    step();
    chk_ifid("stall1", 32'h8, 32'h1111_1111, 32'h8, 1'b1);
    flushIFID = 1'b1;
    step();
    chk_ifid("stall_flush", 32'h8, 32'h1111_1111, 32'h8, 1'b1);
    idle_inputs();

    imem_data = 32'h3333_3333;
    step();
    chk_ifid("seq2", 32'hC, 32'h3333_3333, 32'hC, 1'b1);

    // taken branch redirect with squash
    pc_src = 2'b01; branch_target_ID = 32'h40; flushIFID = 1'b1; imem_data = 32'h4444_4444;
    step();
    chk_ifid("branch", 32'h40, 32'h0, 32'h10, 1'b0);
    chk("branch_imem_addr", {22'd0, imem_addr}, 32'h10);

    // JR redirect
    pc_src = 2'b11; reg_target_ID = 32'h100; imem_data = 32'h5555_5555;
    step();
    chk_ifid("jr", 32'h100, 32'h0, 32'h44, 1'b0);
    chk("jr_imem_addr", {22'd0, imem_addr}, 32'h40);

    // HALT squashed by a jump: discarded, fetch continues
    pc_src = 2'b10; jump_target_ID = 32'h10; imem_data = 32'hFFFF_FFFF;
    step();
    chk_ifid("halt_flushed", 32'h10, 32'h0, 32'h104, 1'b0);
    idle_inputs();

    // HALT fetched at PC=16: PC still advances, proving state was RUN
    imem_data = 32'hFFFF_FFFF;
    step();
    chk_ifid("halt_in_id", 32'h14, 32'hFFFF_FFFF, 32'h14, 1'b1);
    chk("halt_in_id_halted", {31'd0, halted}, 32'h0);
    imem_data = 32'h6666_6666;

    // HALT_HOLD -> DRAIN (counter=3), bubble loaded, PC frozen
    step();
    chk_ifid("drain_entry", 32'h14, 32'h0, 32'h14, 1'b0);
    chk("drain_entry_halted", {31'd0, halted}, 32'h0);
    step();  // counter now 2
    chk("drain_c2_pc", pc_IF, 32'h14);
    chk("drain_c2_halted", {31'd0, halted}, 32'h0);

    // freeze with enable=0 during drain
    enable = 1'b0; stallD = 1'b0;
    step();
    step();
    chk_ifid("frozen", 32'h14, 32'h0, 32'h14, 1'b0);
    chk("frozen_halted", {31'd0, halted}, 32'h0);
    enable = 1'b1;

    step();  // counter 2 -> 1
    chk("drain_c1_halted", {31'd0, halted}, 32'h0);
    step();  // enter HALTED
    chk("halted_entry", {31'd0, halted}, 32'h0);
    step();  // fifth enabled edge after HALT reached ID
    chk("halted_set", {31'd0, halted}, 32'h1);
    pc_src = 2'b10; jump_target_ID = 32'h200;
    step();
    chk_ifid("halted_stay", 32'h14, 32'h0, 32'h14, 1'b0);
    chk("halted_stay_halted", {31'd0, halted}, 32'h1);

    // async reset from HALTED, no clock edge needed
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_halted", {31'd0, halted}, 32'h0);
    chk_ifid("rst_from_halted", 32'h0, 32'h0, 32'h0, 1'b0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // second halt, then reset mid-drain
    imem_data = 32'hFFFF_FFFF;
    step();
    chk_ifid("halt2_in_id", 32'h4, 32'hFFFF_FFFF, 32'h4, 1'b1);
    imem_data = 32'h7777_7777;
    step();
    step();
    chk_ifid("halt2_drain", 32'h4, 32'h0, 32'h4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ifid("rst_mid_drain", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_mid_drain_halted", {31'd0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // fetch resumes normally after reset
    imem_data = 32'h8888_8888;
    step();
    chk_ifid("post_reset", 32'h4, 32'h8888_8888, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
